// File: rtl/image_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : image_stream_reader
// Function : Streams a frame buffer out row by row with vsync/hsync framing
//            and per-pixel pass/threshold/invert processing.
// Revision : 1.0 - initial release
// ============================================================================
module image_stream_reader #(
   parameter int IMG_W       = 768,
   parameter int IMG_H       = 512,
   parameter int PPC         = 2,
   parameter int START_DELAY = 100,
   parameter int HSYNC_DELAY = 160,
   parameter int BOTTOM_UP   = 1,
   parameter int ADDR_W      = 20
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [1:0]          mode,
   input  logic [7:0]          threshold,
   output logic                mem_rd_en,
   output logic [ADDR_W-1:0]   mem_addr,
   input  logic [PPC*24-1:0]   mem_rdata,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [PPC*24-1:0]   out_data,
   output logic                vsync,
   output logic                hsync,
   output logic                busy,
   output logic                done
);

   localparam int BEATS   = IMG_W / PPC;
   localparam int COL_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int RD_W    = $clog2(BEATS + 1);
   localparam int ROW_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int DLY_MAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
   localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
   localparam int DW      = PPC * 24;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_VSYNC = 3'd1;
   localparam logic [2:0] S_HGAP  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [DLY_W-1:0] dly_q, dly_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [RD_W-1:0]  rdcol_q, rdcol_d;
   logic [COL_W-1:0] outcol_q, outcol_d;
   logic [1:0]       mode_q;
   logic [7:0]       thr_q;
   logic             rd_pend_q;
   logic [1:0]       occ_q;
   logic [DW-1:0]    head_q, tail_q;

   logic [ROW_W-1:0]  w_mrow;
   logic [ADDR_W-1:0] w_addr;
   logic [1:0]        w_credit;
   logic              w_pop, w_rd, w_row_end;
   logic [DW-1:0]     w_proc;
   logic [9:0]        w_thr3;

   if (BOTTOM_UP != 0) begin : g_bottom_up
      assign w_mrow = ROW_W'(IMG_H - 1) - row_q;
   end else begin : g_top_down
      assign w_mrow = row_q;
   end

   assign w_addr    = ADDR_W'(w_mrow) * ADDR_W'(BEATS) + ADDR_W'(rdcol_q);
   assign out_valid = (occ_q != 2'd0);
   assign w_pop     = out_valid & out_ready;
   // A beat popped this cycle frees its slot in time for a read issued now.
   assign w_credit  = occ_q + {1'b0, rd_pend_q} - {1'b0, w_pop};
   assign w_rd      = (state_q == S_DATA) && (rdcol_q != RD_W'(BEATS)) && (w_credit < 2'd2);
   assign w_row_end = (state_q == S_DATA) && w_pop && (outcol_q == COL_W'(BEATS - 1));

   assign mem_rd_en = w_rd;
   assign mem_addr  = w_rd ? w_addr : '0;
   assign out_data  = out_valid ? head_q : '0;
   assign vsync     = (state_q == S_VSYNC);
   assign hsync     = (state_q == S_DATA);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

   assign w_thr3 = {2'b00, thr_q} + {1'b0, thr_q, 1'b0};

   for (genvar k = 0; k < PPC; k++) begin : g_pix
      logic [7:0]  r, g, b;
      logic [9:0]  sum;
      logic [23:0] pix;
      assign r   = mem_rdata[24*k+16 +: 8];
      assign g   = mem_rdata[24*k+8  +: 8];
      assign b   = mem_rdata[24*k    +: 8];
      assign sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
      always_comb begin
         pix = {r, g, b};
         case (mode_q)
            2'b01:   pix = (sum > w_thr3) ? 24'hFFFFFF : 24'h000000;
            2'b10:   pix = {8'd255 - r, 8'd255 - g, 8'd255 - b};
            default: pix = {r, g, b};
         endcase
      end
      assign w_proc[24*k +: 24] = pix;
   end

   always_comb begin
      state_d  = state_q;
      dly_d    = dly_q;
      row_d    = row_q;
      rdcol_d  = rdcol_q;
      outcol_d = outcol_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_VSYNC;
               dly_d   = '0;
            end
         end
         S_VSYNC: begin
            if (dly_q == DLY_W'(START_DELAY - 1)) begin
               state_d = S_HGAP;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_HGAP: begin
            if (dly_q == DLY_W'(HSYNC_DELAY - 1)) begin
               state_d = S_DATA;
               dly_d   = '0;
            end else begin
               dly_d = dly_q + 1'b1;
            end
         end
         S_DATA: begin
            if (w_rd)  rdcol_d  = rdcol_q + 1'b1;
            if (w_pop) outcol_d = outcol_q + 1'b1;
            if (w_row_end) begin
               rdcol_d  = '0;
               outcol_d = '0;
               dly_d    = '0;
               if (row_q == ROW_W'(IMG_H - 1)) begin
                  state_d = S_DONE;
                  row_d   = '0;
               end else begin
                  state_d = S_HGAP;
                  row_d   = row_q + 1'b1;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         dly_q    <= '0;
         row_q    <= '0;
         rdcol_q  <= '0;
         outcol_q <= '0;
         mode_q   <= 2'b00;
         thr_q    <= 8'd0;
      end else begin
         state_q  <= state_d;
         dly_q    <= dly_d;
         row_q    <= row_d;
         rdcol_q  <= rdcol_d;
         outcol_q <= outcol_d;
         if (state_q == S_IDLE && start) begin
            mode_q <= mode;
            thr_q  <= threshold;
         end
      end
   end

   // Two-entry output FIFO; head_q is always the beat presented downstream.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_pend_q <= 1'b0;
         occ_q     <= 2'd0;
         head_q    <= '0;
         tail_q    <= '0;
      end else begin
         rd_pend_q <= w_rd;
         case ({rd_pend_q, w_pop})
            2'b10: begin
               if (occ_q == 2'd0) head_q <= w_proc;
               else               tail_q <= w_proc;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               head_q <= tail_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  head_q <= w_proc;
               end else begin
                  head_q <= tail_q;
                  tail_q <= w_proc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
